// File: rtl/mac_vecmat_seq.sv
// mac_vecmat_seq: time-multiplexed z-vector x coefficient-matrix MAC with
// full-precision accumulation, rounding, saturation and per-lane overflow flags.
`default_nettype none

module mac_vecmat_seq #(
  parameter int DW   = 26,
  parameter int FRAC = 13,
  parameter int N    = 4,
  parameter int M    = 16,
  parameter int RND  = 1,
  parameter int SAT  = 1
) (
  input  logic            clk_mul,
  input  logic            rstn_mul,
  input  logic            start,
  input  logic [N*DW-1:0] z_in,
  output logic            busy,
  input  logic            row_valid,
  output logic            row_ready,
  input  logic [M*DW-1:0] row_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M*DW-1:0] out_data,
  output logic [M-1:0]    ovf
);

  localparam int AW = 2*DW + $clog2(N);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);
  localparam logic signed [AW-1:0] RNDC = (RND != 0) ? (AW'(1) << (FRAC-1)) : AW'(0);
  localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, FIN = 2'd2, OUT = 2'd3} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [N*DW-1:0]        z_reg;
  logic signed [AW-1:0]   acc [M];

  logic signed [DW-1:0]   z_cur;
  logic signed [2*DW-1:0] prod [M];
  logic signed [AW-1:0]   acc_nxt [M];
  logic signed [AW-1:0]   t_rnd [M];
  logic signed [AW-1:0]   s_shf [M];
  logic [M*DW-1:0]        fin_data;
  logic [M-1:0]           fin_ovf;

  assign busy      = (state != IDLE);
  assign row_ready = (state == ACC);
  assign out_valid = (state == OUT);

  assign z_cur = z_reg[int'(cnt)*DW +: DW];

  always_comb begin
    fin_data = '0;
    fin_ovf  = '0;
    for (int k = 0; k < M; k++) begin
      prod[k]    = (2*DW)'(z_cur) * (2*DW)'($signed(row_data[k*DW +: DW]));
      acc_nxt[k] = acc[k] + AW'(prod[k]);
      t_rnd[k]   = acc[k] + RNDC;
      s_shf[k]   = t_rnd[k] >>> FRAC;
      fin_ovf[k] = (s_shf[k] > SMAX) || (s_shf[k] < SMIN);
      // Overflow is flagged even in wrap mode so downstream can detect aliasing.
      if (SAT != 0) begin
        if (s_shf[k] > SMAX)
          fin_data[k*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
        else if (s_shf[k] < SMIN)
          fin_data[k*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
        else
          fin_data[k*DW +: DW] = s_shf[k][DW-1:0];
      end else begin
        fin_data[k*DW +: DW] = s_shf[k][DW-1:0];
      end
    end
  end

  always_ff @(posedge clk_mul) begin
    if (!rstn_mul) begin
      state    <= IDLE;
      cnt      <= '0;
      z_reg    <= '0;
      out_data <= '0;
      ovf      <= '0;
      for (int k = 0; k < M; k++) acc[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            z_reg <= z_in;
            cnt   <= '0;
            for (int k = 0; k < M; k++) acc[k] <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (row_valid) begin
            for (int k = 0; k < M; k++) acc[k] <= acc_nxt[k];
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIN;
          end
        end
        FIN: begin
          out_data <= fin_data;
          ovf      <= fin_ovf;
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            // A start coinciding with the result handshake chains the next operation.
            if (start) begin
              z_reg <= z_in;
              cnt   <= '0;
              for (int k = 0; k < M; k++) acc[k] <= '0;
              state <= ACC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_vecmat_seq.sv
// Directed self-checking bench for mac_vecmat_seq: three instances share stimulus
// (RND=1/SAT=1, RND=0/SAT=1, RND=1/SAT=0) so rounding and wrap modes are compared side by side.
`timescale 1ns/1ps
`default_nettype none

module tb_mac_vecmat_seq;
  localparam int DW = 26, FRAC = 13, N = 4, M = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn, start, row_valid, out_ready;
  logic [N*DW-1:0] z_in;
  logic [M*DW-1:0] row_data;
  logic            busy_a, rr_a, ov_a, busy_t, rr_t, ov_t, busy_w, rr_w, ov_w;
  logic [M*DW-1:0] od_a, od_t, od_w;
  logic [M-1:0]    of_a, of_t, of_w;

  mac_vecmat_seq #(.DW(DW), .FRAC(FRAC), .N(N), .M(M), .RND(1), .SAT(1)) dut_a (
    .clk_mul(clk), .rstn_mul(rstn), .start(start), .z_in(z_in), .busy(busy_a),
    .row_valid(row_valid), .row_ready(rr_a), .row_data(row_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .ovf(of_a));
  mac_vecmat_seq #(.DW(DW), .FRAC(FRAC), .N(N), .M(M), .RND(0), .SAT(1)) dut_t (
    .clk_mul(clk), .rstn_mul(rstn), .start(start), .z_in(z_in), .busy(busy_t),
    .row_valid(row_valid), .row_ready(rr_t), .row_data(row_data),
    .out_valid(ov_t), .out_ready(out_ready), .out_data(od_t), .ovf(of_t));
  mac_vecmat_seq #(.DW(DW), .FRAC(FRAC), .N(N), .M(M), .RND(1), .SAT(0)) dut_w (
    .clk_mul(clk), .rstn_mul(rstn), .start(start), .z_in(z_in), .busy(busy_w),
    .row_valid(row_valid), .row_ready(rr_w), .row_data(row_data),
    .out_valid(ov_w), .out_ready(out_ready), .out_data(od_w), .ovf(of_w));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [M*DW-1:0] rows [N];
  logic [M*DW-1:0] held;
  logic [M*DW-1:0] lanes_exp;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_d(input string tag, input logic [M*DW-1:0] obs, input logic [M*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_f(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [M*DW-1:0] rep(input logic [DW-1:0] v);
    logic [M*DW-1:0] r;
    for (int k = 0; k < M; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [N*DW-1:0] zv(input int a0, input int a1, input int a2, input int a3);
    logic [N*DW-1:0] r;
    r[0*DW +: DW] = DW'(a0);
    r[1*DW +: DW] = DW'(a1);
    r[2*DW +: DW] = DW'(a2);
    r[3*DW +: DW] = DW'(a3);
    return r;
  endfunction

  task automatic set_rows(input int r0, input int r1, input int r2, input int r3);
    rows[0] = rep(DW'(r0));
    rows[1] = rep(DW'(r1));
    rows[2] = rep(DW'(r2));
    rows[3] = rep(DW'(r3));
  endtask

  // Issue start, stream the rows (optional 2-cycle gap after row gap_row), wait for
  // out_valid and return the latency in edges measured from the start edge.
  task automatic run_op(input logic [N*DW-1:0] z, input int gap_row, output int lat);
    int s;
    int n;
    start = 1'b1;
    z_in  = z;
    tick;
    start = 1'b0;
    s = cyc;
    for (int j = 0; j < N; j++) begin
      row_valid = 1'b1;
      row_data  = rows[j];
      tick;
      if (j == gap_row) begin
        row_valid = 1'b0;
        tick;
        tick;
      end
    end
    row_valid = 1'b0;
    n = 0;
    while (!ov_a && n < 20) begin
      tick;
      n++;
    end
    chk_b("out_valid_timeout", ov_a, 1'b1);
    lat = cyc - s;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    rstn = 1'b0; start = 1'b0; row_valid = 1'b0; out_ready = 1'b0;
    z_in = '0; row_data = '0;
    tick;
    tick;
    rstn = 1'b1;
    chk_b("rst_busy", busy_a, 1'b0);
    chk_b("rst_row_ready", rr_a, 1'b0);
    chk_b("rst_out_valid", ov_a, 1'b0);
    chk_d("rst_out_data", od_a, '0);
    chk_f("rst_ovf", of_a, '0);

    // Unity: 4 x 1.0 x 1.0 = 4.0
    set_rows(8192, 8192, 8192, 8192);
    run_op(zv(8192, 8192, 8192, 8192), -1, lat);
    chk_i("unity_latency", lat, N+1);
    chk_d("unity_a", od_a, rep(DW'(32768)));
    chk_d("unity_t", od_t, rep(DW'(32768)));
    chk_d("unity_w", od_w, rep(DW'(32768)));
    chk_f("unity_ovf", of_a, '0);
    consume;
    chk_b("unity_idle_busy", busy_a, 1'b0);
    chk_b("unity_idle_valid", ov_a, 1'b0);
    chk_d("unity_data_kept", od_a, rep(DW'(32768)));

    // Lane/row dependent: z[j]=(j+1), C[j][k]=(j+1)(k+1) -> o[k]=30(k+1) in Q13
    for (int j = 0; j < N; j++)
      for (int k = 0; k < M; k++) rows[j][k*DW +: DW] = DW'((j+1)*(k+1)*8192);
    for (int k = 0; k < M; k++) lanes_exp[k*DW +: DW] = DW'(30*(k+1)*8192);
    run_op(zv(8192, 16384, 24576, 32768), -1, lat);
    chk_d("lanes_a", od_a, lanes_exp);
    chk_d("lanes_w", od_w, lanes_exp);
    consume;

    // Rounding: z={1,0,0,0}, row0 = 4096 / -4096 / -4097
    set_rows(4096, 0, 0, 0);
    run_op(zv(1, 0, 0, 0), -1, lat);
    chk_d("rnd_p4096_rnd1", od_a, rep(DW'(1)));
    chk_d("rnd_p4096_rnd0", od_t, rep(DW'(0)));
    chk_f("rnd_p4096_ovf", of_a, '0);
    consume;
    set_rows(-4096, 0, 0, 0);
    run_op(zv(1, 0, 0, 0), -1, lat);
    chk_d("rnd_m4096_rnd1", od_a, rep(DW'(0)));
    chk_d("rnd_m4096_rnd0", od_t, rep(DW'(-1)));
    consume;
    set_rows(-4097, 0, 0, 0);
    run_op(zv(1, 0, 0, 0), -1, lat);
    chk_d("rnd_m4097_rnd0", od_t, rep(DW'(-1)));
    chk_d("rnd_m4097_rnd1", od_a, rep(DW'(-1)));
    consume;

    // Saturation / wrap, positive: s = 2^39 - 2^15
    set_rows(33554431, 33554431, 33554431, 33554431);
    run_op(zv(33554431, 33554431, 33554431, 33554431), -1, lat);
    chk_d("sat_pos_a", od_a, rep(DW'(33554431)));
    chk_f("sat_pos_ovf_a", of_a, '1);
    chk_d("sat_pos_t", od_t, rep(DW'(33554431)));
    chk_d("wrap_pos_w", od_w, rep(26'h3FF8000));
    chk_f("wrap_pos_ovf_w", of_w, '1);
    consume;
    // Negative: s = -2^39 + 2^14
    run_op(zv(-33554432, -33554432, -33554432, -33554432), -1, lat);
    chk_d("sat_neg_a", od_a, rep(26'h2000000));
    chk_f("sat_neg_ovf_a", of_a, '1);
    chk_d("wrap_neg_w", od_w, rep(DW'(16384)));
    chk_f("wrap_neg_ovf_w", of_w, '1);
    consume;

    // Row gap of 2 cycles: same result, 2 edges later
    set_rows(8192, 8192, 8192, 8192);
    run_op(zv(8192, 8192, 8192, 8192), 1, lat);
    chk_i("gap_latency", lat, N+3);
    chk_d("gap_data", od_a, rep(DW'(32768)));
    chk_f("gap_ovf", of_a, '0);

    // Output backpressure with start toggling
    held = od_a;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      z_in  = zv(i, i, i, i);
      tick;
      chk_b("bp_valid", ov_a, 1'b1);
      chk_b("bp_busy", busy_a, 1'b1);
      chk_b("bp_row_ready", rr_a, 1'b0);
      chk_d("bp_data", od_a, held);
    end
    start = 1'b0;
    consume;
    chk_b("bp_done_busy", busy_a, 1'b0);

    // Reset after 2 of 4 rows
    for (int j = 0; j < N; j++)
      for (int k = 0; k < M; k++) rows[j][k*DW +: DW] = DW'((k+1)*8192);
    run_op(zv(8192, 8192, 8192, 8192), -1, lat);
    consume;
    start = 1'b1;
    z_in  = zv(8192, 8192, 8192, 8192);
    tick;
    start = 1'b0;
    row_valid = 1'b1;
    row_data  = rows[0];
    tick;
    tick;
    row_valid = 1'b0;
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    chk_b("mrst_busy", busy_a, 1'b0);
    chk_b("mrst_row_ready", rr_a, 1'b0);
    chk_b("mrst_valid", ov_a, 1'b0);
    chk_d("mrst_data", od_a, '0);
    chk_f("mrst_ovf", of_a, '0);
    tick;
    chk_b("mrst_idle_next", busy_a, 1'b0);
    set_rows(8192, 8192, 8192, 8192);
    run_op(zv(8192, 8192, 8192, 8192), -1, lat);
    chk_d("mrst_fresh", od_a, rep(DW'(32768)));

    // Back-to-back: handshake + start on the same edge, new z = 2.0
    out_ready = 1'b1;
    start     = 1'b1;
    z_in      = zv(16384, 16384, 16384, 16384);
    tick;
    out_ready = 1'b0;
    start     = 1'b0;
    chk_b("b2b_valid_drop", ov_a, 1'b0);
    chk_b("b2b_row_ready", rr_a, 1'b1);
    chk_b("b2b_busy", busy_a, 1'b1);
    for (int j = 0; j < N; j++) begin
      row_valid = 1'b1;
      row_data  = rows[j];
      tick;
    end
    row_valid = 1'b0;
    chk_b("b2b_fin_not_valid", ov_a, 1'b0);
    tick;
    chk_b("b2b_valid", ov_a, 1'b1);
    chk_d("b2b_data", od_a, rep(DW'(65536)));
    consume;
    chk_b("b2b_idle", busy_a, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
